// File: rtl/line_motor_ctrl.sv
// One-side line-follower motor controller: synchronised and debounced sensor and proximity inputs,
// a brake/forward/reverse FSM with brake dead-time, PWM on the H-bridge enable, and line-lost reverse search.
module line_motor_ctrl #(
  parameter int N_SENS   = 4,
  parameter int TURN_IDX = 0,
  parameter int PWM_W    = 8,
  parameter int DEB_CYC  = 4,
  parameter int DEAD_CYC = 8,
  parameter int LOST_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SENS-1:0] sens,
  input  logic              prox,
  input  logic [PWM_W-1:0]  duty_fwd,
  input  logic [PWM_W-1:0]  duty_rev,
  output logic              en1,
  output logic              in1,
  output logic              in2,
  output logic [1:0]        state,
  output logic              lost
);

  // state    | meaning
  // ST_BRAKE | both bridge inputs high, dead-time counting
  // ST_FWD   | forward drive, PWM on en1 from dutyf_q
  // ST_REV   | reverse search, PWM on en1 from dutyr_q
  typedef enum logic [1:0] {ST_BRAKE = 2'd0, ST_FWD = 2'd1, ST_REV = 2'd2} state_e;

  localparam int NB  = N_SENS + 1;
  localparam int DBW = (DEB_CYC  > 1) ? $clog2(DEB_CYC + 1)  : 1;
  localparam int DTW = $clog2(DEAD_CYC + 1);
  localparam int LCW = $clog2(LOST_CYC + 1);
  localparam logic [DBW-1:0] DEB_LAST = DBW'(DEB_CYC - 1);
  localparam logic [DTW-1:0] DEAD_MAX = DTW'(DEAD_CYC);
  localparam logic [LCW-1:0] LOST_MAX = LCW'(LOST_CYC);

  logic [NB-1:0]           sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d;
  logic [NB-1:0][DBW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [LCW-1:0]          lost_cnt_q, lost_cnt_d;
  logic [DTW-1:0]          dead_cnt_q, dead_cnt_d;
  logic [PWM_W-1:0]        pwm_cnt_q, pwm_cnt_d, dutyf_q, dutyf_d, dutyr_q, dutyr_d;
  state_e                  state_q, state_d, req;
  logic [N_SENS-1:0]       sens_f;
  logic                    obst, all_clr;

  // Bit N_SENS of the input path carries prox, the rest carry the sensors.
  assign sens_f  = filt_q[N_SENS-1:0];
  assign obst    = ~filt_q[N_SENS];
  assign all_clr = ~|sens_f;

  always_comb begin
    sync1_d    = {prox, sens};
    sync2_d    = sync1_q;
    filt_d     = filt_q;
    deb_cnt_d  = '0;
    for (int i = 0; i < NB; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) filt_d[i] = sync2_q[i];
        else                           deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
    lost_cnt_d = '0;
    if (all_clr && !obst)
      lost_cnt_d = (lost_cnt_q == LOST_MAX) ? lost_cnt_q : lost_cnt_q + 1'b1;
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    dutyf_d   = (pwm_cnt_q == '0) ? duty_fwd : dutyf_q;
    dutyr_d   = (pwm_cnt_q == '0) ? duty_rev : dutyr_q;
  end

  always_comb begin
    req = ST_FWD;
    if (obst)                  req = ST_BRAKE;
    else if (sens_f[TURN_IDX]) req = ST_BRAKE;
    else if (all_clr)          req = (lost_cnt_q == LOST_MAX) ? ST_REV : ST_BRAKE;
  end

  always_comb begin
    state_d    = state_q;
    dead_cnt_d = '0;
    case (state_q)
      ST_BRAKE: begin
        dead_cnt_d = (dead_cnt_q == DEAD_MAX) ? dead_cnt_q : dead_cnt_q + 1'b1;
        if (dead_cnt_q == DEAD_MAX && req != ST_BRAKE) state_d = req;
      end
      ST_FWD:  if (req != ST_FWD) state_d = ST_BRAKE;
      ST_REV:  if (req != ST_REV) state_d = ST_BRAKE;
      default: state_d = ST_BRAKE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BRAKE;
      dead_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dead_cnt_q <= dead_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_q     <= '0;
      deb_cnt_q  <= '0;
      lost_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      dutyf_q    <= '0;
      dutyr_q    <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      filt_q     <= filt_d;
      deb_cnt_q  <= deb_cnt_d;
      lost_cnt_q <= lost_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      dutyf_q    <= dutyf_d;
      dutyr_q    <= dutyr_d;
    end
  end

  always_comb begin
    en1 = 1'b1;
    in1 = 1'b1;
    in2 = 1'b1;
    case (state_q)
      ST_FWD: begin
        in1 = 1'b0;
        en1 = (pwm_cnt_q < dutyf_q);
      end
      ST_REV: begin
        in2 = 1'b0;
        en1 = (pwm_cnt_q < dutyr_q);
      end
      default: ;
    endcase
  end

  assign state = state_q;
  assign lost  = (lost_cnt_q == LOST_MAX);

endmodule

// File: tb/tb_line_motor_ctrl.sv
// Bench for line_motor_ctrl: directed timing scenarios plus random pin activity,
// every cycle compared against a run-length / rule-based reference model.
module tb_line_motor_ctrl;
  localparam int N_SENS   = 4;
  localparam int TURN_IDX = 0;
  localparam int PWM_W    = 8;
  localparam int DEB_CYC  = 4;
  localparam int DEAD_CYC = 8;
  localparam int LOST_CYC = 64;
  localparam int PERIOD   = 1 << PWM_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_SENS-1:0] sens;
  logic              prox;
  logic [PWM_W-1:0]  duty_fwd, duty_rev;
  logic              en1, in1, in2, lost;
  logic [1:0]        state;

  always #5 clk = ~clk;

  line_motor_ctrl #(
    .N_SENS(N_SENS), .TURN_IDX(TURN_IDX), .PWM_W(PWM_W),
    .DEB_CYC(DEB_CYC), .DEAD_CYC(DEAD_CYC), .LOST_CYC(LOST_CYC)
  ) dut (
    .clk(clk), .rst(rst), .sens(sens), .prox(prox),
    .duty_fwd(duty_fwd), .duty_rev(duty_rev),
    .en1(en1), .in1(in1), .in2(in2), .state(state), .lost(lost)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: pin samples kept newest-first; a filtered bit flips when the
  // last DEB_CYC synchronised samples (two edges old and older) all disagree with it.
  bit                m_valid = 0;
  int                cyc = 0;
  logic [N_SENS:0]   m_hist[$];
  logic [N_SENS:0]   m_filt;
  int                m_lost, m_state, m_age, m_pwm, m_dutyf, m_dutyr;

  task automatic model_step();
    logic [N_SENS-1:0] sf;
    bit obst, clr, all_diff;
    int req, nstate;
    sf   = m_filt[N_SENS-1:0];
    obst = !m_filt[N_SENS];
    clr  = (sf == '0);
    if (obst)              req = 0;
    else if (sf[TURN_IDX]) req = 0;
    else if (clr)          req = (m_lost == LOST_CYC) ? 2 : 0;
    else                   req = 1;
    if (m_state == 0) nstate = (m_age >= DEAD_CYC && req != 0) ? req : 0;
    else              nstate = (req == m_state) ? m_state : 0;
    m_age   = (m_state == 0 && nstate == 0) ? m_age + 1 : 0;
    m_state = nstate;
    m_lost  = (clr && !obst) ? ((m_lost < LOST_CYC) ? m_lost + 1 : LOST_CYC) : 0;
    if (m_pwm == 0) begin
      m_dutyf = int'(duty_fwd);
      m_dutyr = int'(duty_rev);
    end
    m_pwm = (m_pwm + 1) % PERIOD;
    for (int b = 0; b <= N_SENS; b++) begin
      all_diff = 1;
      for (int k = 1; k <= DEB_CYC; k++)
        if (m_hist[k][b] == m_filt[b]) all_diff = 0;
      if (all_diff) m_filt[b] = ~m_filt[b];
    end
    m_hist.push_front({prox, sens});
    void'(m_hist.pop_back());
  endtask

  function automatic logic [5:0] model_outs();
    logic [5:0] r;
    r[5:4] = 2'(m_state);
    r[0]   = (m_lost == LOST_CYC);
    case (m_state)
      1:       r[3:1] = {(m_pwm < m_dutyf), 1'b0, 1'b1};
      2:       r[3:1] = {(m_pwm < m_dutyr), 1'b1, 1'b0};
      default: r[3:1] = 3'b111;
    endcase
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_valid = 1;
      m_hist.delete();
      for (int i = 0; i < DEB_CYC + 2; i++) m_hist.push_back('0);
      m_filt = '0; m_lost = 0; m_state = 0; m_age = 0;
      m_pwm = 0; m_dutyf = 0; m_dutyr = 0;
    end else if (m_valid) begin
      model_step();
    end
  end

  int adj_err = 0;
  logic [1:0] prev_state = 2'd0;
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check_val("cycle", {26'd0, state, en1, in1, in2, lost}, {26'd0, model_outs()});
      if ((prev_state == 2'd1 && state == 2'd2) || (prev_state == 2'd2 && state == 2'd1))
        adj_err++;
      prev_state = state;
    end
  end

  task automatic wait_state(input logic [1:0] s, input int lim, output int lat);
    int t0;
    t0  = cyc;
    lat = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (state == s) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  initial begin
    int lat, t0, hi, bad, lost_lat, len;
    rst = 1'b1; sens = '0; prox = 1'b0; duty_fwd = 8'd64; duty_rev = 8'd128;
    repeat (3) @(negedge clk);
    check_val("reset_outs", {26'd0, state, en1, in1, in2, lost}, 32'b00_1110);

    rst = 1'b0; sens = 4'b0110; prox = 1'b1;
    wait_state(2'd1, 40, lat);
    check_val("fwd_after_reset", lat, DEAD_CYC + 1);

    hi = 0;
    repeat (PERIOD) begin hi += int'(en1); @(negedge clk); end
    check_val("pwm_duty64", hi, 64);

    prox = 1'b0;
    repeat (DEB_CYC - 1) @(negedge clk);
    prox = 1'b1;
    bad = 0;
    repeat (15) begin @(negedge clk); if (state != 2'd1) bad++; end
    check_val("prox_glitch", bad, 0);

    prox = 1'b0;
    wait_state(2'd0, 40, lat);
    check_val("obst_latency", lat, DEB_CYC + 3);
    check_val("obst_outs", {en1, in1, in2}, 3'b111);

    prox = 1'b1;
    wait_state(2'd1, 60, lat);
    check_val("refwd", state, 2'd1);

    sens = '0;
    t0 = cyc;
    wait_state(2'd0, 40, lat);
    check_val("lost_brake", lat, DEB_CYC + 3);
    lost_lat = -1;
    for (int i = 0; i < 120; i++) begin
      if (lost) begin lost_lat = cyc - t0; break; end
      @(negedge clk);
    end
    check_val("lost_latency", lost_lat, DEB_CYC + 2 + LOST_CYC);
    wait_state(2'd2, 40, lat);
    check_val("rev_latency", cyc - t0, DEB_CYC + 3 + LOST_CYC);
    check_val("rev_pins", {in1, in2}, 2'b10);

    sens = 4'b0110;
    wait_state(2'd1, 60, lat);
    check_val("refwd2", state, 2'd1);

    for (int i = 0; i < PERIOD + 4 && m_pwm != 0; i++) @(negedge clk);
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (m_pwm == 100) duty_fwd = 8'd200;
      hi += int'(en1);
      @(negedge clk);
    end
    check_val("duty_old_period", hi, 64);
    hi = 0;
    repeat (PERIOD) begin hi += int'(en1); @(negedge clk); end
    check_val("duty_new_period", hi, 200);

    sens = '0;
    wait_state(2'd2, 150, lat);
    check_val("rev_again", state, 2'd2);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_in_rev", {26'd0, state, en1, in1, in2, lost}, 32'b00_1110);
    rst = 1'b0;
    bad = 0;
    repeat (DEAD_CYC + 1) begin @(negedge clk); if (state != 2'd0) bad++; end
    check_val("holdoff_restart", bad, 0);

    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        sens = '0; prox = 1'b1;
        len  = $urandom_range(60, 120);
      end else begin
        sens = N_SENS'($urandom);
        if ($urandom_range(0, 3) != 0) sens[TURN_IDX] = 1'b0;
        prox = ($urandom_range(0, 7) != 0);
        len  = $urandom_range(1, 12);
      end
      if ($urandom_range(0, 5) == 0) duty_fwd = PWM_W'($urandom);
      if ($urandom_range(0, 5) == 0) duty_rev = PWM_W'($urandom);
      if ($urandom_range(0, 40) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      repeat (len) @(negedge clk);
    end

    check_val("no_fwd_rev_adjacent", adj_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
